// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks in-flight register writes and raises a decode stall until results are forwardable
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   i_issue_valid        instruction leaves decode this cycle
//   i_issue_regwrite     issued instruction writes i_issue_rd
//   i_issue_rd           destination register of the issued instruction
//   i_issue_lat          cycles until that result can be forwarded
//   i_dec_rs1/2          decode-stage source registers
//   i_wb_valid, i_wb_rd  writeback retiring a register write
//   i_flush              squash every in-flight write
//   o_stall              hold decode/fetch and bubble execute
//   o_rs1/2_pending      source has an in-flight write (forwarding needed)
//   o_pending_cnt        number of registers currently pending
//   o_stall_cycles       saturating stalled-cycle counter (only with SCOREBOARD_STATS_EN)
//
// Build option: define SCOREBOARD_STATS_EN to add o_stall_cycles.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_issue_valid,
    input  logic             i_issue_regwrite,
    input  logic [AW-1:0]    i_issue_rd,
    input  logic [LAT_W-1:0] i_issue_lat,
    input  logic [AW-1:0]    i_dec_rs1,
    input  logic [AW-1:0]    i_dec_rs2,
    input  logic             i_wb_valid,
    input  logic [AW-1:0]    i_wb_rd,
    input  logic             i_flush,
    output logic             o_stall,
    output logic             o_rs1_pending,
    output logic             o_rs2_pending,
    output logic [AW:0]      o_pending_cnt
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [31:0]      o_stall_cycles
`endif
);
    logic [NREG-1:0]             r_pend, w_pend_nx;
    logic [NREG-1:0][LAT_W-1:0]  r_cnt, w_cnt_nx;
    logic [AW:0]                 r_pending_cnt, w_pop;
    logic                        w_stall, w_accept;

    assign o_rs1_pending = i_dec_rs1 != '0 && r_pend[i_dec_rs1];
    assign o_rs2_pending = i_dec_rs2 != '0 && r_pend[i_dec_rs2];
    assign w_stall = (o_rs1_pending && r_cnt[i_dec_rs1] != '0) ||
                     (o_rs2_pending && r_cnt[i_dec_rs2] != '0);
    assign w_accept = i_issue_valid && i_issue_regwrite && i_issue_rd != '0 && !w_stall && !i_flush;
    assign o_stall = w_stall;
    assign o_pending_cnt = r_pending_cnt;

    // Order inside the loop sets priority: countdown < writeback < issue < flush/reg0.
    always_comb begin
        w_pend_nx = r_pend;
        w_cnt_nx = r_cnt;
        w_pop = '0;
        for (int i = 0; i < NREG; i++) begin
            w_cnt_nx[i] = r_cnt[i] != '0 ? r_cnt[i] - LAT_W'(1) : '0;
            if (i_wb_valid && i_wb_rd == AW'(i)) begin
                w_pend_nx[i] = 1'b0;
                w_cnt_nx[i] = '0;
            end
            if (w_accept && i_issue_rd == AW'(i)) begin
                w_pend_nx[i] = 1'b1;
                w_cnt_nx[i] = i_issue_lat;
            end
            if (i_flush || i == 0) begin
                w_pend_nx[i] = 1'b0;
                w_cnt_nx[i] = '0;
            end
            w_pop = w_pop + (AW+1)'(w_pend_nx[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_cnt <= '0;
            r_pending_cnt <= '0;
        end else begin
            r_pend <= w_pend_nx;
            r_cnt <= w_cnt_nx;
            r_pending_cnt <= w_pop;
        end
    end

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (w_stall && ~&r_stall_cycles)
            r_stall_cycles <= r_stall_cycles + 32'd1;
    end
    assign o_stall_cycles = r_stall_cycles;
`endif
endmodule
